// File: rtl/axis_boxcar_decimator_v1_0.sv
// Boxcar averaging decimator: averages each block of 2^LOG2_RATIO signed
// AXI-Stream samples into one sign-extended output word.
// Optional macro AXIS_BOXCAR_ROUND_EN: round half toward +inf instead of floor.
module axis_boxcar_decimator_v1_0 #(
    parameter int S_AXIS_TDATA_WIDTH = 16,
    parameter int M_AXIS_TDATA_WIDTH = 32,
    parameter int LOG2_RATIO         = 4
) (
    input  logic                          aclk,
    input  logic                          arst,
    output logic                          s_axis_tready,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid
);

    localparam int N     = 1 << LOG2_RATIO;
    localparam int ACC_W = S_AXIS_TDATA_WIDTH + LOG2_RATIO;
    localparam int CNT_W = (LOG2_RATIO > 0) ? LOG2_RATIO : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

`ifdef AXIS_BOXCAR_ROUND_EN
    // Half of the divisor; zero when there is no division at all.
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(N >> 1);
`else
    localparam logic signed [ACC_W-1:0] RND = '0;
`endif

    logic signed [ACC_W-1:0]              r_acc;
    logic [CNT_W-1:0]                     r_cnt;
    logic [M_AXIS_TDATA_WIDTH-1:0]        r_data;
    logic                                 r_valid;

    logic                                 w_s_ready;
    logic                                 w_accept;
    logic                                 w_last;
    logic signed [ACC_W-1:0]              w_sample;
    logic signed [ACC_W-1:0]              w_sum;
    logic signed [ACC_W-1:0]              w_rnd;
    logic signed [ACC_W-1:0]              w_avg;
    logic [M_AXIS_TDATA_WIDTH-1:0]        w_avg_ext;

    // Handshake, block-end detection and the averaged result of the block.
    always_comb begin
        w_s_ready = ~r_valid | m_axis_tready;
        w_accept  = s_axis_tvalid & w_s_ready;
        w_last    = (r_cnt == CNT_LAST);
        w_sample  = ACC_W'($signed(s_axis_tdata));
        w_sum     = r_acc + w_sample;
        w_rnd     = w_sum + RND;
        w_avg     = w_rnd >>> LOG2_RATIO;
        w_avg_ext = M_AXIS_TDATA_WIDTH'(
                        $signed(w_avg[S_AXIS_TDATA_WIDTH-1:0]));
    end

    // Accumulate accepted samples; close the block on the Nth one.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Output register: load on block end, hold under backpressure.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_accept && w_last) begin
            r_data  <= w_avg_ext;
            r_valid <= 1'b1;
        end else if (m_axis_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tdata  = r_data;
    assign m_axis_tvalid = r_valid;

endmodule

// File: tb/tb_axis_boxcar_decimator_v1_0.sv
// Scoreboard bench for the boxcar decimator (S=16, M=32, LOG2_RATIO=2).
// Expected averages are queued at stimulus time and popped on each transfer.
module tb_axis_boxcar_decimator_v1_0;

    logic        aclk;
    logic        arst;
    logic        s_axis_tready;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;

    int n_checks = 0;
    int n_err    = 0;
    int n_out    = 0;
    logic [31:0] exp_q[$];

    axis_boxcar_decimator_v1_0 #(
        .S_AXIS_TDATA_WIDTH(16),
        .M_AXIS_TDATA_WIDTH(32),
        .LOG2_RATIO(2)
    ) dut (
        .aclk(aclk),
        .arst(arst),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Software block average of four samples.
    function automatic logic [31:0] avg4(input int sum);
`ifdef AXIS_BOXCAR_ROUND_EN
        return 32'((sum + 2) >>> 2);
`else
        return 32'(sum >>> 2);
`endif
    endfunction

    // Pop and compare every completed output transfer.
    always @(negedge aclk) begin
        if (!arst && m_axis_tvalid && m_axis_tready) begin
            n_out++;
            if (exp_q.size() == 0)
                chk("extra_output", m_axis_tdata, 32'hDEAD_BEEF);
            else
                chk("out_data", m_axis_tdata, exp_q.pop_front());
        end
    end

    // Drive one sample until it is accepted (bounded).
    task automatic send(input logic [15:0] v);
        bit ok;
        int t;
        ok = 1'b0;
        t  = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = v;
        while (!ok && t < 50) begin
            @(negedge aclk);
            ok = s_axis_tready;
            @(posedge aclk);
            #1;
            t++;
        end
        s_axis_tvalid = 1'b0;
        if (!ok)
            chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_sum;
        int acc_n;
        int accepted;
        int out0;

        arst          = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        idle(3);
        chk("rst_valid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_data", m_axis_tdata, 32'd0);
        arst = 1'b0;
        idle(1);
        chk("rst_tready", 32'(s_axis_tready), 32'd1);

        // 1,2,3,4 back to back
`ifdef AXIS_BOXCAR_ROUND_EN
        exp_q.push_back(32'd3);
`else
        exp_q.push_back(32'd2);
`endif
        send(16'd1);
        send(16'd2);
        send(16'd3);
        chk("early_valid", 32'(m_axis_tvalid), 32'd0);
        send(16'd4);
        chk("lat_valid", 32'(m_axis_tvalid), 32'd1);

        // negative block
`ifdef AXIS_BOXCAR_ROUND_EN
        exp_q.push_back(32'hFFFF_FFFF);
`else
        exp_q.push_back(32'hFFFF_FFFE);
`endif
        send(16'hFFFF);
        send(16'hFFFF);
        send(16'hFFFF);
        send(16'hFFFE);

        // extremes, no wrap
        exp_q.push_back(32'h0000_7FFF);
        repeat (4) send(16'h7FFF);
        exp_q.push_back(32'hFFFF_8000);
        repeat (4) send(16'h8000);
        idle(2);

        // backpressure
        m_axis_tready = 1'b0;
        exp_q.push_back(32'd5);
        repeat (4) send(16'd5);
        chk("bp_valid", 32'(m_axis_tvalid), 32'd1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'd7;
        repeat (3) begin
            @(negedge aclk);
            chk("bp_tready", 32'(s_axis_tready), 32'd0);
            chk("bp_hold", m_axis_tdata, 32'd5);
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        exp_q.push_back(32'd7);
        repeat (4) send(16'd7);
        idle(2);

        // reset mid-block
        send(16'd100);
        send(16'd100);
        arst = 1'b1;
        idle(2);
        chk("rst2_valid", 32'(m_axis_tvalid), 32'd0);
        arst = 1'b0;
        idle(1);
        chk("rst2_tready", 32'(s_axis_tready), 32'd1);
        exp_q.push_back(32'd4);
        send(16'd4);
        send(16'd4);
        send(16'd4);
        chk("rst2_nv", 32'(m_axis_tvalid), 32'd0);
        send(16'd4);
        chk("rst2_v", 32'(m_axis_tvalid), 32'd1);
        idle(2);
        chk("drain1", 32'(exp_q.size()), 32'd0);

        // random gapped stream
        acc_sum  = 0;
        acc_n    = 0;
        accepted = 0;
        out0     = n_out;
        for (int i = 0; i < 400; i++) begin
            s_axis_tvalid = 1'($urandom_range(0, 1));
            s_axis_tdata  = 16'($urandom);
            @(negedge aclk);
            if (s_axis_tvalid && s_axis_tready) begin
                accepted++;
                acc_sum += int'($signed(s_axis_tdata));
                acc_n++;
                if (acc_n == 4) begin
                    exp_q.push_back(avg4(acc_sum));
                    acc_sum = 0;
                    acc_n   = 0;
                end
            end
            @(posedge aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        idle(4);
        chk("rand_count", 32'(n_out - out0), 32'(accepted / 4));
        chk("drain2", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_boxcar_decimator_v1_0.md
AXIS_BOXCAR_DECIMATOR_V1_0 -- requirements
Module: axis_boxcar_decimator_v1_0

Interface
REQ-001 SHALL have parameter S_AXIS_TDATA_WIDTH, default 16, input sample width (signed two's complement).
REQ-002 SHALL have parameter M_AXIS_TDATA_WIDTH, default 32, output word width; legal only if M_AXIS_TDATA_WIDTH >= S_AXIS_TDATA_WIDTH.
REQ-003 SHALL have parameter LOG2_RATIO, default 4, decimation ratio N = 2^LOG2_RATIO, legal range 0..8.
REQ-004 SHALL have aclk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have arst  input  1  synchronous, active-high reset.
REQ-006 SHALL have s_axis_tready  output  1  input accept.
REQ-007 SHALL have s_axis_tdata  input  S_AXIS_TDATA_WIDTH  signed input sample.
REQ-008 SHALL have s_axis_tvalid  input  1  input sample valid.
REQ-009 SHALL have m_axis_tready  input  1  downstream accept.
REQ-010 SHALL have m_axis_tdata  output  M_AXIS_TDATA_WIDTH  block average, sign-extended.
REQ-011 SHALL have m_axis_tvalid  output  1  output register holds an unconsumed average.

Function
REQ-012 SHALL accept an input sample only on a cycle where s_axis_tvalid and s_axis_tready are both 1.
REQ-013 SHALL drive s_axis_tready = ~m_axis_tvalid | m_axis_tready (combinational); no sample ever dropped.
REQ-014 SHALL keep an accumulator of width S_AXIS_TDATA_WIDTH+LOG2_RATIO (no overflow possible) and a sample counter 0..N-1.
REQ-015 SHALL, on an accepted sample with counter < N-1, add the sign-extended sample to the accumulator and increment the counter.
REQ-016 SHALL, on an accepted sample with counter = N-1, load the output register with (accumulator + sample) arithmetically shifted right by LOG2_RATIO, sign-extended to M_AXIS_TDATA_WIDTH, set m_axis_tvalid, clear accumulator and counter to 0.
REQ-017 SHALL present the average on m_axis_tdata/m_axis_tvalid the cycle after the Nth sample is accepted (latency 1 cycle).
REQ-018 SHALL hold m_axis_tdata and m_axis_tvalid stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-019 SHALL clear m_axis_tvalid after a cycle with m_axis_tvalid=1 and m_axis_tready=1, unless the same cycle completes a new block (then load new average, m_axis_tvalid stays 1).
REQ-020 SHALL, with LOG2_RATIO=0, behave as a 1-cycle registered pass-through with sign extension.
REQ-021 SHALL keep counter and accumulator unchanged on cycles with no accepted sample (gaps in s_axis_tvalid allowed mid-block).

Reset
REQ-022 SHALL, while arst=1 at a clock edge, clear accumulator, counter, output register data to 0 and m_axis_tvalid to 0.
REQ-023 SHALL discard any partial block and any unconsumed output on reset; first output after reset covers exactly the first N samples accepted after reset.
REQ-024 SHALL drive s_axis_tready=1 in the cycle following reset deassertion.

Configuration
REQ-025 SHALL, with macro AXIS_BOXCAR_ROUND_EN defined, add 2^(LOG2_RATIO-1) to the final sum before the shift (round half toward +infinity); for LOG2_RATIO=0 no offset is added.
REQ-026 SHALL, without AXIS_BOXCAR_ROUND_EN, truncate by arithmetic shift (floor toward -infinity).

Verification (S=16, M=32, LOG2_RATIO=2, N=4)
REQ-027 SHALL cover: inputs 1,2,3,4 back-to-back, m_axis_tready=1 -> one output 2 (0x00000002) without macro, 3 with AXIS_BOXCAR_ROUND_EN, 1 cycle after 4th accept.
REQ-028 SHALL cover: inputs -1,-1,-1,-2 -> output -2 (0xFFFFFFFE) without macro, -1 (0xFFFFFFFF) with macro.
REQ-029 SHALL cover: four inputs 0x7FFF then four inputs 0x8000 -> outputs 32767 then -32768, no wrap.
REQ-030 SHALL cover: m_axis_tready=0 with output valid, s_axis_tvalid=1 -> s_axis_tready=0, output data stable; raising m_axis_tready resumes acceptance that cycle, no sample lost or duplicated.
REQ-031 SHALL cover: arst pulsed after 2 of 4 samples (values 100,100), then 4,4,4,4 -> single output 4, m_axis_tvalid=0 during and after reset until 4th post-reset accept.
REQ-032 SHALL cover: continuous stream with m_axis_tready=1 and gapped s_axis_tvalid (random 50%) -> output count = floor(accepted/4), values match software floor average.
